// File: rtl/wr_slot_sched.sv
// Write-transaction slot scheduler: tracks outstanding AXI writes through AW -> W -> B and times each phase.
// Optional feature: define WR_SLOT_SCHED_ERR_EN to flag B handshakes that match no waiting slot.
module wr_slot_sched #(
   parameter int NumSlots = 4,
   parameter int IdWidth  = 4,
   parameter int CntWidth = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  prescaled_en_i,
   input  logic                  aw_valid_i,
   input  logic                  aw_ready_i,
   input  logic [IdWidth-1:0]    aw_id_i,
   input  logic                  w_valid_i,
   input  logic                  w_ready_i,
   input  logic                  w_last_i,
   input  logic                  b_valid_i,
   input  logic                  b_ready_i,
   input  logic [IdWidth-1:0]    b_id_i,
   input  logic [CntWidth-1:0]   budget_aw_i,
   input  logic [CntWidth-1:0]   budget_w_i,
   input  logic [CntWidth-1:0]   budget_b_i,
   input  logic                  irq_clr_i,
   output logic                  full_o,
   output logic [NumSlots-1:0]   slot_free_o,
   output logic [2*NumSlots-1:0] slot_state_o,
   output logic [NumSlots-1:0]   timeout_o,
   output logic                  irq_o,
   output logic                  err_unexp_b_o
);

   localparam int SlotW = $clog2(NumSlots);

   typedef enum logic [1:0] {
      FREE           = 2'd0,
      WRITE_ADDRESS  = 2'd1,
      WRITE_DATA     = 2'd2,
      WRITE_RESPONSE = 2'd3
   } slot_state_e;

   // Handshakes are plain valid && ready; the snooped channels are never back-pressured by this block.
   slot_state_e         state_q [NumSlots];
   slot_state_e         state_d [NumSlots];
   logic [IdWidth-1:0]  id_q    [NumSlots];
   logic [IdWidth-1:0]  id_d    [NumSlots];
   logic [CntWidth-1:0] cnt_q   [NumSlots];
   logic [CntWidth-1:0] cnt_d   [NumSlots];
   logic [NumSlots-1:0] older_q [NumSlots];
   logic [NumSlots-1:0] older_d [NumSlots];
   logic [SlotW-1:0]    fifo_q  [NumSlots];
   logic [SlotW-1:0]    fifo_d  [NumSlots];
   logic [CntWidth-1:0] phase_budget [NumSlots];
   logic [SlotW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [SlotW:0]      fifo_cnt_q, fifo_cnt_d;
   logic [NumSlots-1:0] timeout_q, timeout_d, to_set;
   logic                irq_q;
   logic [NumSlots-1:0] free_vec, b_match, b_sel;
   logic [SlotW-1:0]    alloc_idx, head;
   logic                aw_hs, b_hs, push, pop;

   assign aw_hs = aw_valid_i && aw_ready_i;
   assign b_hs  = b_valid_i && b_ready_i;

   always_comb begin
      free_vec     = '0;
      slot_state_o = '0;
      for (int s = 0; s < NumSlots; s++) begin
         free_vec[s]            = (state_q[s] == FREE);
         slot_state_o[2*s +: 2] = state_q[s];
      end
   end

   assign full_o      = ~|free_vec;
   assign slot_free_o = free_vec;
   assign timeout_o   = timeout_q;
   assign irq_o       = irq_q;

   always_comb begin
      alloc_idx = '0;
      for (int s = NumSlots - 1; s >= 0; s--) begin
         if (free_vec[s]) alloc_idx = SlotW'(s);
      end
   end

   // older_q[i][j] set means slot i was allocated before slot j; the oldest match has no older match.
   always_comb begin
      b_match = '0;
      b_sel   = '0;
      for (int s = 0; s < NumSlots; s++) begin
         b_match[s] = (state_q[s] == WRITE_RESPONSE) && (id_q[s] == b_id_i);
      end
      for (int s = 0; s < NumSlots; s++) begin
         b_sel[s] = b_match[s];
         for (int j = 0; j < NumSlots; j++) begin
            if (j != s && b_match[j] && older_q[j][s]) b_sel[s] = 1'b0;
         end
      end
   end

   always_comb begin
      to_set = '0;
      for (int s = 0; s < NumSlots; s++) begin
         case (state_q[s])
            WRITE_ADDRESS: phase_budget[s] = budget_aw_i;
            WRITE_DATA:    phase_budget[s] = budget_w_i;
            default:       phase_budget[s] = budget_b_i;
         endcase
         to_set[s] = (state_q[s] != FREE) && (cnt_q[s] >= phase_budget[s]);
      end
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      older_d    = older_q;
      fifo_d     = fifo_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      head       = fifo_q[rd_ptr_q];
      push       = aw_hs && !full_o;
      pop        = 1'b0;
      timeout_d  = (timeout_q & ~{NumSlots{irq_clr_i}}) | to_set;

      for (int s = 0; s < NumSlots; s++) begin
         if (state_q[s] != FREE && prescaled_en_i && cnt_q[s] != '1) begin
            cnt_d[s] = cnt_q[s] + CntWidth'(1);
         end
      end

      // Only the FIFO head may consume W traffic; AXI write data follows AW order.
      if (fifo_cnt_q != '0 && w_valid_i) begin
         if (state_q[head] == WRITE_ADDRESS) begin
            cnt_d[head] = '0;
            if (w_ready_i && w_last_i) begin
               state_d[head] = WRITE_RESPONSE;
               pop           = 1'b1;
            end else begin
               state_d[head] = WRITE_DATA;
            end
         end else if (state_q[head] == WRITE_DATA && w_ready_i && w_last_i) begin
            state_d[head] = WRITE_RESPONSE;
            cnt_d[head]   = '0;
            pop           = 1'b1;
         end
      end

      if (b_hs) begin
         for (int s = 0; s < NumSlots; s++) begin
            if (b_sel[s]) begin
               state_d[s] = FREE;
               cnt_d[s]   = '0;
            end
         end
      end

      if (push) begin
         state_d[alloc_idx] = WRITE_ADDRESS;
         id_d[alloc_idx]    = aw_id_i;
         cnt_d[alloc_idx]   = '0;
         fifo_d[wr_ptr_q]   = alloc_idx;
         wr_ptr_d           = wr_ptr_q + SlotW'(1);
         for (int i = 0; i < NumSlots; i++) begin
            older_d[i][alloc_idx] = (i != int'(alloc_idx));
         end
         older_d[alloc_idx] = '0;
      end

      if (pop) rd_ptr_d = rd_ptr_q + SlotW'(1);
      if (push && !pop) fifo_cnt_d = fifo_cnt_q + (SlotW+1)'(1);
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - (SlotW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NumSlots; s++) begin
            state_q[s] <= FREE;
            id_q[s]    <= '0;
            cnt_q[s]   <= '0;
            older_q[s] <= '0;
            fifo_q[s]  <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         timeout_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         for (int s = 0; s < NumSlots; s++) begin
            state_q[s] <= state_d[s];
            id_q[s]    <= id_d[s];
            cnt_q[s]   <= cnt_d[s];
            older_q[s] <= older_d[s];
            fifo_q[s]  <= fifo_d[s];
         end
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         timeout_q  <= timeout_d;
         irq_q      <= |timeout_q;
      end
   end

`ifdef WR_SLOT_SCHED_ERR_EN
   logic err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= b_hs && !(|b_match);
   end

   assign err_unexp_b_o = err_q;
`else
   assign err_unexp_b_o = 1'b0;
`endif

endmodule

// File: tb/tb_wr_slot_sched.sv
// Directed bench for wr_slot_sched: slot lifecycle, full handling, age ordering, timeouts, same-cycle events.
// Expected error pulses depend on WR_SLOT_SCHED_ERR_EN.
module tb_wr_slot_sched;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       prescaled_en_i = 1'b0;
   logic       aw_valid_i = 1'b0, aw_ready_i = 1'b0;
   logic [3:0] aw_id_i = '0;
   logic       w_valid_i = 1'b0, w_ready_i = 1'b0, w_last_i = 1'b0;
   logic       b_valid_i = 1'b0, b_ready_i = 1'b0;
   logic [3:0] b_id_i = '0;
   logic [7:0] budget_aw_i = 8'hFF, budget_w_i = 8'hFF, budget_b_i = 8'hFF;
   logic       irq_clr_i = 1'b0;
   logic       full_o, irq_o, err_unexp_b_o;
   logic [3:0] slot_free_o, timeout_o;
   logic [7:0] slot_state_o;

   int         n_vec = 0;
   int         n_err = 0;
   logic [1:0] exp_q[$];
   logic       exp_err;

   wr_slot_sched dut (
      .clk_i(clk_i), .rst_i(rst_i), .prescaled_en_i(prescaled_en_i),
      .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_id_i(aw_id_i),
      .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_id_i(b_id_i),
      .budget_aw_i(budget_aw_i), .budget_w_i(budget_w_i), .budget_b_i(budget_b_i),
      .irq_clr_i(irq_clr_i), .full_o(full_o), .slot_free_o(slot_free_o),
      .slot_state_o(slot_state_o), .timeout_o(timeout_o), .irq_o(irq_o),
      .err_unexp_b_o(err_unexp_b_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic aw(input logic [3:0] id);
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = id;
      tick();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0;
   endtask

   task automatic w_beat(input logic last);
      w_valid_i = 1'b1; w_ready_i = 1'b1; w_last_i = last;
      tick();
      w_valid_i = 1'b0; w_ready_i = 1'b0; w_last_i = 1'b0;
   endtask

   task automatic b_resp(input logic [3:0] id);
      b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = id;
      tick();
      b_valid_i = 1'b0; b_ready_i = 1'b0;
   endtask

   initial begin
`ifdef WR_SLOT_SCHED_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif

      // 1: single transaction lifecycle
      do_reset();
      check("rst_free", slot_free_o, 4'hF);
      check("rst_state", slot_state_o, 8'h00);
      check("rst_full", full_o, 1'b0);
      check("rst_timeout", timeout_o, 4'h0);
      check("rst_irq", irq_o, 1'b0);
      check("rst_err", err_unexp_b_o, 1'b0);
      exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      aw(4'd3);
      check("t1_aw_state", slot_state_o[1:0], exp_q.pop_front());
      check("t1_aw_free", slot_free_o, 4'b1110);
      w_beat(1'b0);
      check("t1_w1_state", slot_state_o[1:0], exp_q.pop_front());
      w_beat(1'b1);
      check("t1_wlast_state", slot_state_o[1:0], exp_q.pop_front());
      b_resp(4'd3);
      check("t1_b_state", slot_state_o[1:0], exp_q.pop_front());
      check("t1_b_free", slot_free_o, 4'hF);

      // 2: fill all slots, overflow AW ignored, unexpected B
      do_reset();
      for (int i = 0; i < 4; i++) aw(4'(i));
      check("t2_full", full_o, 1'b1);
      check("t2_free", slot_free_o, 4'h0);
      check("t2_state", slot_state_o, 8'h55);
      aw(4'd7);
      check("t2_ovf_state", slot_state_o, 8'h55);
      check("t2_ovf_full", full_o, 1'b1);
      b_resp(4'd9);
      check("t2_err_pulse", err_unexp_b_o, exp_err);
      check("t2_b_nostate", slot_state_o, 8'h55);
      tick();
      check("t2_err_drop", err_unexp_b_o, 1'b0);
      // FIFO head must still be slot0: a single-beat W completes slot0 only
      w_beat(1'b1);
      check("t2_head_slot0", slot_state_o, 8'h57);

      // 3: same ID in two slots, oldest freed first even when it has the higher index
      do_reset();
      aw(4'd5);
      aw(4'd5);
      w_beat(1'b1);
      w_beat(1'b1);
      check("t3_both_resp", slot_state_o, 8'h0F);
      b_resp(4'd5);
      check("t3_b_oldest", slot_state_o, 8'h0C);
      aw(4'd5);
      w_beat(1'b1);
      check("t3_realloc", slot_state_o, 8'h0F);
      b_resp(4'd5);
      check("t3_b_age", slot_state_o, 8'h03);

      // 4: address-phase timeout, irq, clear, set-wins-over-clear with budget 0
      do_reset();
      budget_aw_i = 8'd3;
      prescaled_en_i = 1'b1;
      aw(4'd1);
      tick(); tick(); tick();
      check("t4_to_pre", timeout_o, 4'h0);
      tick();
      check("t4_to_set", timeout_o, 4'h1);
      check("t4_irq_lag", irq_o, 1'b0);
      tick();
      check("t4_irq_set", irq_o, 1'b1);
      budget_aw_i = 8'd200;
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      check("t4_to_clr", timeout_o, 4'h0);
      tick();
      check("t4_irq_clr", irq_o, 1'b0);
      budget_aw_i = 8'd0;
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      check("t4_set_wins", timeout_o, 4'h1);
      prescaled_en_i = 1'b0;
      budget_aw_i = 8'hFF;

      // 5: single-beat W skips WRITE_DATA, empty FIFO ignores W
      do_reset();
      check("t5_rst_timeout", timeout_o, 4'h0);
      aw(4'd2);
      w_beat(1'b1);
      check("t5_direct", slot_state_o, 8'h03);
      w_beat(1'b1);
      check("t5_empty_w", slot_state_o, 8'h03);
      aw(4'd4);
      check("t5_aw2", slot_state_o, 8'h07);
      w_valid_i = 1'b1; w_ready_i = 1'b0; w_last_i = 1'b1;
      tick();
      w_valid_i = 1'b0; w_last_i = 1'b0;
      check("t5_w_noready", slot_state_o, 8'h0B);

      // 6: B frees slot0 while AW arrives with all slots busy
      do_reset();
      for (int i = 0; i < 4; i++) aw(4'(i));
      for (int i = 0; i < 4; i++) w_beat(1'b1);
      check("t6_all_resp", slot_state_o, 8'hFF);
      aw_valid_i = 1'b1; aw_ready_i = 1'b1; aw_id_i = 4'd9;
      b_valid_i = 1'b1; b_ready_i = 1'b1; b_id_i = 4'd0;
      tick();
      aw_valid_i = 1'b0; aw_ready_i = 1'b0;
      b_valid_i = 1'b0; b_ready_i = 1'b0;
      check("t6_state", slot_state_o, 8'hFC);
      check("t6_free", slot_free_o, 4'b0001);
      check("t6_full", full_o, 1'b0);
      aw(4'd9);
      check("t6_realloc", slot_state_o, 8'hFD);
      check("t6_full2", full_o, 1'b1);

      // mid-operation reset discards everything
      do_reset();
      check("rst_mid_free", slot_free_o, 4'hF);
      check("rst_mid_state", slot_state_o, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
